uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter for the SoC RS-232 link. It is the line-side end of the display path's tx_data/tx_wr/tx_flag handshake.
- Accepts 8-bit characters into a one-deep holding register and serializes them onto the DCE TXD pin as 8N1 (or 8N2) frames.
- tx_flag tells the display peripheral when another character may be written.

Parameters:
- CLKS_PER_BIT, 488: eclk cycles per bit period (56.25 MHz / 115200 baud). Legal range is 2 or more.
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2.

Ports:
- eclk, input, 1: emulation clock. Single clock domain.
- ereset_n, input, 1: asynchronous, active-low reset.
- tx_data, input, 8: character to send. Sampled only on an accepted write.
- tx_wr, input, 1: write strobe, one cycle wide. Accepted only when tx_flag=1.
- tx_flag, output, 1: 1 when the holding register is empty and a write will be accepted.
- overrun, output, 1: sticky. Set by a tx_wr that arrives while tx_flag=0.
- overrun_clr, input, 1: clears overrun on the next edge.
- busy, output, 1: 1 while the shifter is in any state other than IDLE.
- rs232_dce_txd, output, 1: serial line output. Idles high.

Behaviour:
- Reset (ereset_n=0, asynchronous):
  - rs232_dce_txd=1, tx_flag=1, busy=0, overrun=0.
  - Holding register is emptied; state=IDLE; bit and baud counters are 0.
  - Reset asserted mid-frame aborts the frame. txd goes high immediately, not on a clock edge.
  - Release is synchronous to eclk; the first write is accepted on the first edge after release.
- Holding register:
  - tx_wr=1 with tx_flag=1 at edge N latches tx_data; tx_flag=0 after edge N.
  - tx_wr=1 with tx_flag=0 leaves the holding register untouched and sets overrun after that edge.
  - If tx_wr and overrun_clr occur in the same cycle, set wins.
- Shifter state machine has states IDLE, START, DATA, STOP:
  - IDLE, holding register full at edge N: load the shifter, empty the holding register, enter START. After edge N: txd=0, busy=1, tx_flag=1.
  - Write-to-start-bit latency is therefore 1 cycle when idle.
  - START: hold txd=0 for CLKS_PER_BIT cycles, then enter DATA.
  - DATA: send bits 0..7, LSB first, each held for CLKS_PER_BIT cycles. After bit 7, enter STOP.
  - STOP: hold txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final STOP cycle edge, with the holding register full: reload and enter START directly. There is no idle gap; frames are exactly (9+STOP_BITS)*CLKS_PER_BIT cycles apart.
  - On the final STOP cycle edge, with the holding register empty: enter IDLE, busy=0.
- Other rules:
  - txd is driven directly from a flop; no combinational path from any input to txd.
  - tx_data changes after acceptance have no effect on the frame in flight.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is the clog2 of CLKS_PER_BIT*STOP_BITS; the counter does not overflow at maximum stop length.
  - Capacity is two characters in flight: one in the shifter, one in the holding register. A third write while both are occupied is dropped and flagged as overrun.

Test Plan:
- Reset release, no writes: txd=1, tx_flag=1, busy=0, overrun=0 held for 100 cycles.
- CLKS_PER_BIT=4, STOP_BITS=1, write 0x55:
  - txd low starting 1 cycle after the write.
  - Bit-period sequence is 0,1,0,1,0,1,0,1,0,1, 4 cycles each (40 cycles total).
  - busy falls after cycle 40; tx_flag is 1 again 1 cycle after the write.
- CLKS_PER_BIT=4, write 0xA3, then write 0x0F at cycle 2:
  - The second frame's start bit begins exactly 40 cycles after the first's.
  - Decoded bytes are 0xA3 then 0x0F; no overrun.
- Write 0x11, 0x22, then 0x33 on three consecutive tx_flag=1-independent cycles while the shifter is busy:
  - 0x33 is dropped; overrun=1 and stays set.
  - overrun_clr pulse clears it on the next edge.
  - Only 0x11 and 0x22 appear on the line.
- STOP_BITS=2, CLKS_PER_BIT=4, back-to-back 0xFF, 0x00: stop interval is 8 cycles high; frame pitch is 44 cycles.
- Assert ereset_n=0 mid-way through data bit 3 of 0x00:
  - txd=1 immediately, without waiting for an edge.
  - After release: tx_flag=1, busy=0, and no residual frame is emitted.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1/8N2 serial transmitter with a one-deep holding register in front of the shifter.
// The line output comes straight from a flop and is forced high by reset without waiting for a clock edge.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 488,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       eclk,
    input  logic       ereset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_flag,
    output logic       overrun,
    input  logic       overrun_clr,
    output logic       busy,
    output logic       rs232_dce_txd
);

    localparam int unsigned STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
    localparam int unsigned CNT_W     = (STOP_CLKS > 2) ? $clog2(STOP_CLKS) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             overrun_q, overrun_d;
    logic             txd_q, txd_d;
    logic             accept;
    logic             load;

    assign accept = tx_wr & ~hold_full_q;

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            overrun_q   <= overrun_d;
            txd_q       <= txd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;
        txd_d       = txd_q;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Reloading from the last stop cycle keeps consecutive frames gap-free.
        if (load) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = hold_q;
            txd_d   = 1'b0;
        end

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end

        if (tx_wr && hold_full_q) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    assign tx_flag       = ~hold_full_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != IDLE);
    assign rs232_dce_txd = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance with 1 stop bit, one with 2, both at 4 clocks per bit.
// An independent line decoder per instance records each received byte and its start-bit cycle.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       eclk = 1'b0;
    logic       ereset_n;
    logic [7:0] tx_data1, tx_data2;
    logic       tx_wr1, tx_wr2;
    logic       overrun_clr1, overrun_clr2;
    logic       tx_flag1, tx_flag2;
    logic       overrun1, overrun2;
    logic       busy1, busy2;
    logic       txd1, txd2;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cycle_count = 0;

    logic [7:0] q1_data[$];
    int         q1_time[$];
    logic [7:0] q2_data[$];
    int         q2_time[$];

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .eclk          (eclk),
        .ereset_n      (ereset_n),
        .tx_data       (tx_data1),
        .tx_wr         (tx_wr1),
        .tx_flag       (tx_flag1),
        .overrun       (overrun1),
        .overrun_clr   (overrun_clr1),
        .busy          (busy1),
        .rs232_dce_txd (txd1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .eclk          (eclk),
        .ereset_n      (ereset_n),
        .tx_data       (tx_data2),
        .tx_wr         (tx_wr2),
        .tx_flag       (tx_flag2),
        .overrun       (overrun2),
        .overrun_clr   (overrun_clr2),
        .busy          (busy2),
        .rs232_dce_txd (txd2)
    );

    always #5 eclk = ~eclk;

    always @(posedge eclk) cycle_count <= cycle_count + 1;

    task automatic tick;
        @(posedge eclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] data);
        if (sel == 1) begin
            tx_data1 = data;
            tx_wr1   = 1'b1;
        end else begin
            tx_data2 = data;
            tx_wr2   = 1'b1;
        end
        tick();
        tx_wr1 = 1'b0;
        tx_wr2 = 1'b0;
    endtask

    function automatic logic get_txd(input int sel);
        return (sel == 1) ? txd1 : txd2;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? busy1 : busy2;
    endfunction

    // Called one cycle into the start bit's first sample; samples the middle of every bit period.
    task automatic decode_frame(input int sel, output logic [7:0] b, output bit ok);
        ok = 1'b1;
        b  = '0;
        for (int c = 1; c <= 9 * CPB + CPB / 2; c++) begin
            tick();
            if (!ereset_n) begin
                ok = 1'b0;
                return;
            end
            if (c == CPB / 2 && get_txd(sel) !== 1'b0) ok = 1'b0;
            if (c >= CPB + CPB / 2 && c < 9 * CPB && ((c - CPB / 2) % CPB) == 0)
                b[(c - CPB / 2) / CPB - 1] = get_txd(sel);
            if (c == 9 * CPB + CPB / 2 && get_txd(sel) !== 1'b1) ok = 1'b0;
        end
    endtask

    always begin : mon1
        logic [7:0] b;
        bit         ok;
        int         t;
        tick();
        if (ereset_n && txd1 === 1'b0) begin
            t = cycle_count;
            decode_frame(1, b, ok);
            if (ok) begin
                q1_data.push_back(b);
                q1_time.push_back(t);
            end
        end
    end

    always begin : mon2
        logic [7:0] b;
        bit         ok;
        int         t;
        tick();
        if (ereset_n && txd2 === 1'b0) begin
            t = cycle_count;
            decode_frame(2, b, ok);
            if (ok) begin
                q2_data.push_back(b);
                q2_time.push_back(t);
            end
        end
    end

    task automatic wait_idle(input int sel, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (get_busy(sel) == 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit          ok;
        int          bad;
        int          run_len;
        logic [39:0] cap;

        ereset_n     = 1'b0;
        tx_data1     = '0;
        tx_data2     = '0;
        tx_wr1       = 1'b0;
        tx_wr2       = 1'b0;
        overrun_clr1 = 1'b0;
        overrun_clr2 = 1'b0;
        #20;
        ereset_n = 1'b1;

        // Idle after reset release
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (txd1 !== 1'b1 || tx_flag1 !== 1'b1 || busy1 !== 1'b0 || overrun1 !== 1'b0) bad++;
        end
        checkOutput("idle_txd", txd1, 1'b1);
        checkOutput("idle_flag", tx_flag1, 1'b1);
        checkOutput("idle_busy", busy1, 1'b0);
        checkOutput("idle_overrun", overrun1, 1'b0);
        checkOutput("idle_100_cycles_bad", bad, 0);

        // Single frame 0x55, captured cycle by cycle
        q1_data.delete();
        q1_time.delete();
        applyStimulus(1, 8'h55);
        checkOutput("flag_after_wr", tx_flag1, 1'b0);
        tick();
        checkOutput("flag_1cyc_after_wr", tx_flag1, 1'b1);
        checkOutput("busy_at_start", busy1, 1'b1);
        cap[0] = txd1;
        for (int k = 1; k < 40; k++) begin
            tick();
            cap[k] = txd1;
        end
        checkOutput("wave_55", cap, 40'hF0F0F0F0F0);
        checkOutput("busy_cycle40", busy1, 1'b1);
        tick();
        checkOutput("busy_fall_41", busy1, 1'b0);
        checkOutput("dec55_count", q1_data.size(), 1);
        if (q1_data.size() >= 1) checkOutput("dec55_byte", q1_data[0], 8'h55);

        // Back-to-back 0xA3 then 0x0F
        q1_data.delete();
        q1_time.delete();
        applyStimulus(1, 8'hA3);
        tick();
        applyStimulus(1, 8'h0F);
        wait_idle(1, 300, ok);
        checkOutput("b2b_idle_reached", ok, 1'b1);
        checkOutput("b2b_count", q1_data.size(), 2);
        if (q1_data.size() >= 2) begin
            checkOutput("b2b_byte0", q1_data[0], 8'hA3);
            checkOutput("b2b_byte1", q1_data[1], 8'h0F);
            checkOutput("b2b_pitch", q1_time[1] - q1_time[0], 40);
        end
        checkOutput("b2b_no_overrun", overrun1, 1'b0);

        // Third write while shifter and holding register are both full
        q1_data.delete();
        q1_time.delete();
        applyStimulus(1, 8'h11);
        tick();
        applyStimulus(1, 8'h22);
        applyStimulus(1, 8'h33);
        checkOutput("ovr_set", overrun1, 1'b1);
        checkOutput("ovr_flag_low", tx_flag1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("ovr_sticky", overrun1, 1'b1);
        overrun_clr1 = 1'b1;
        applyStimulus(1, 8'h44);
        overrun_clr1 = 1'b0;
        checkOutput("ovr_set_beats_clr", overrun1, 1'b1);
        overrun_clr1 = 1'b1;
        tick();
        overrun_clr1 = 1'b0;
        checkOutput("ovr_cleared", overrun1, 1'b0);
        wait_idle(1, 300, ok);
        checkOutput("ovr_idle_reached", ok, 1'b1);
        checkOutput("ovr_count", q1_data.size(), 2);
        if (q1_data.size() >= 2) begin
            checkOutput("ovr_byte0", q1_data[0], 8'h11);
            checkOutput("ovr_byte1", q1_data[1], 8'h22);
        end

        // Two stop bits: 0xFF then 0x00
        q2_data.delete();
        q2_time.delete();
        applyStimulus(2, 8'hFF);
        tick();
        applyStimulus(2, 8'h00);
        ok = 1'b0;
        run_len = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy2 == 1'b0) begin
                ok = 1'b1;
                break;
            end
            run_len = (txd2 === 1'b1) ? run_len + 1 : 0;
        end
        checkOutput("stop2_idle_reached", ok, 1'b1);
        checkOutput("stop2_high_len", run_len, 8);
        checkOutput("stop2_count", q2_data.size(), 2);
        if (q2_data.size() >= 2) begin
            checkOutput("stop2_byte0", q2_data[0], 8'hFF);
            checkOutput("stop2_byte1", q2_data[1], 8'h00);
            checkOutput("stop2_pitch", q2_time[1] - q2_time[0], 44);
        end

        // Reset in the middle of data bit 3 of 0x00
        q1_data.delete();
        q1_time.delete();
        applyStimulus(1, 8'h00);
        tick();
        for (int i = 0; i < 17; i++) tick();
        checkOutput("rst_txd_before", txd1, 1'b0);
        checkOutput("rst_busy_before", busy1, 1'b1);
        #2;
        ereset_n = 1'b0;
        #1;
        checkOutput("rst_txd_async", txd1, 1'b1);
        checkOutput("rst_busy_async", busy1, 1'b0);
        tick();
        tick();
        @(negedge eclk);
        ereset_n = 1'b1;
        #1;
        checkOutput("rel_flag", tx_flag1, 1'b1);
        checkOutput("rel_busy", busy1, 1'b0);
        checkOutput("rel_overrun", overrun1, 1'b0);
        applyStimulus(1, 8'h5A);
        checkOutput("rel_first_wr", tx_flag1, 1'b0);
        wait_idle(1, 300, ok);
        checkOutput("rel_idle_reached", ok, 1'b1);
        checkOutput("rel_count", q1_data.size(), 1);
        if (q1_data.size() >= 1) checkOutput("rel_byte", q1_data[0], 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
